// File: rtl/vga_fetch.sv
// vga_fetch: 640x480@60 timing generator and framebuffer reader (160x120, 4x4 replicated), VGA_TESTPATTERN_EN selects bars.
// Latency: 2 pixel ticks from counters to hsync/vsync/colour; free-running, no backpressure.
module vga_fetch #(
  parameter int          CLK_DIV   = 2,
  parameter logic [14:0] BASE_ADDR = 15'd0,
  parameter int          FB_WIDTH  = 160
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [14:0] VGAAddress,
  input  logic [15:0] VGADataIn,
  output logic        hsync,
  output logic        vsync,
  output logic [2:0]  red,
  output logic [2:0]  green,
  output logic [1:0]  blue,
  output logic        vblank,
  output logic        frameTick
);

  logic [1:0]  divCnt;
  logic [9:0]  hc, vc, hcNext, vcNext;
  logic [14:0] rowBase;
  logic        tick, hcWrap, vcWrap;
  logic        hsyncRaw, vsyncRaw, active;
  logic [7:0]  pixSrc, pixRaw;
  logic        unusedData;

  assign tick   = (divCnt == 2'(CLK_DIV - 1));
  assign hcWrap = (hc == 10'd799);
  assign vcWrap = (vc == 10'd524);

  always_comb begin
    hcNext = hcWrap ? 10'd0 : hc + 10'd1;
    vcNext = vc;
    if (hcWrap) vcNext = vcWrap ? 10'd0 : vc + 10'd1;
  end

  // Each stored pixel covers 4 screen columns; address parks on the row base during blanking.
  assign VGAAddress = rowBase + ((hc < 10'd640) ? {7'd0, hc[9:2]} : 15'd0);

`ifdef VGA_TESTPATTERN_EN
  assign pixSrc     = {hc[9:7], vc[8:6], hc[6:5]};
  assign unusedData = ^VGADataIn;
`else
  assign pixSrc     = VGADataIn[7:0];
  assign unusedData = ^VGADataIn[15:8];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      divCnt    <= 2'd0;
      hc        <= 10'd0;
      vc        <= 10'd0;
      rowBase   <= BASE_ADDR;
      hsyncRaw  <= 1'b1;
      vsyncRaw  <= 1'b1;
      active    <= 1'b0;
      pixRaw    <= 8'd0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      {red, green, blue} <= 8'd0;
      vblank    <= 1'b0;
      frameTick <= 1'b0;
    end else begin
      divCnt    <= tick ? 2'd0 : divCnt + 2'd1;
      frameTick <= tick & hcWrap & (vc == 10'd479);
      if (tick) begin
        hc     <= hcNext;
        vc     <= vcNext;
        vblank <= (vcNext >= 10'd480);
        // Row base steps after the 4th replicated line of each stored row.
        if (hcWrap) begin
          if (vcWrap)
            rowBase <= BASE_ADDR;
          else if (vc[1:0] == 2'd3 && vc < 10'd479)
            rowBase <= rowBase + 15'(FB_WIDTH);
        end
        hsyncRaw <= !(hc >= 10'd656 && hc <= 10'd751);
        vsyncRaw <= !(vc >= 10'd490 && vc <= 10'd491);
        active   <= (hc < 10'd640) && (vc < 10'd480);
        pixRaw   <= pixSrc;
        hsync    <= hsyncRaw;
        vsync    <= vsyncRaw;
        {red, green, blue} <= active ? pixRaw : 8'd0;
      end
    end
  end

endmodule
